// File: rtl/sinhron_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sinhron_pkg
//  Description : Shared types and constants for the synchronisation pulse
//                generator: channel FSM state encoding, channel indices and
//                configuration reset values.
//  Revision    : 1.0 - initial release
// ============================================================================
package sinhron_pkg;

    // Per-channel strobe FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2,
        DONE  = 2'd3
    } ch_state_t;

    // Channel index of each time-match flag
    localparam int CH_TNO  = 0;
    localparam int CH_TNC  = 1;
    localparam int CH_TOBM = 2;
    localparam int CH_TNI  = 3;
    localparam int CH_TKI  = 4;
    localparam int CH_TNP  = 5;
    localparam int CH_TKP  = 6;

    // Configuration values restored by reset, in ticks
    localparam logic [7:0] DEF_DELAY = 8'd0;
    localparam logic [7:0] DEF_WIDTH = 8'd10;

endpackage
`default_nettype wire

// File: rtl/sinhron_pulse_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sinhron_pulse_gen_if
//  Description : Bus-side signal bundle of the synchronisation pulse
//                generator: match flags, arm strobes, configuration write
//                port and the per-channel strobe/status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sinhron_pulse_gen_if #(
    parameter int N_CH = 7
);
    logic [N_CH-1:0] mk_in;
    logic [N_CH-1:0] arm;
    logic            cfg_we;
    logic [3:0]      cfg_adr;
    logic [15:0]     cfg_data;
    logic [N_CH-1:0] pulse_out;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] done;
    logic            tick_out;

    // Driver side (timer-compare block / bus host)
    modport master (
        output mk_in, arm, cfg_we, cfg_adr, cfg_data,
        input  pulse_out, busy, done, tick_out
    );

    // Pulse generator side
    modport slave (
        input  mk_in, arm, cfg_we, cfg_adr, cfg_data,
        output pulse_out, busy, done, tick_out
    );
endinterface
`default_nettype wire

// File: rtl/sinhron_pulse_gen_ch.sv
`default_nettype none
// ============================================================================
//  Module      : sinhron_pulse_ch
//  Description : One strobe channel: IDLE -> DELAY -> PULSE -> DONE state
//                machine with a tick-driven down counter. Delay and width
//                are sampled at the trigger, so later config writes only
//                affect the next strobe.
//                Optional macro SINHRON_PULSE_MISS_CNT_EN adds a 4-bit
//                saturating count of triggers that arrived while busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
module sinhron_pulse_ch
    import sinhron_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             trig_i,
    input  logic             arm_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SINHRON_PULSE_MISS_CNT_EN
    ,
    output logic [3:0]       miss_cnt_o
`endif
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] wlat_q,  wlat_d;
    logic             pulse_q, pulse_d;

    // A programmed width of 0 still yields a one-tick strobe
    logic [CNT_W-1:0] w_trig_width;
    logic [CNT_W-1:0] w_lat_width;
    assign w_trig_width = (width_i == '0) ? CNT_W'(1) : width_i;
    assign w_lat_width  = (wlat_q  == '0) ? CNT_W'(1) : wlat_q;

    // State, counter, latched width and strobe registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wlat_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wlat_q  <= wlat_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic; arm aborts from any state and beats a same-cycle trigger
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wlat_d  = wlat_q;
        pulse_d = pulse_q;
        if (arm_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig_i) begin
                        wlat_d = width_i;
                        if (delay_i == '0) begin
                            state_d = PULSE;
                            cnt_d   = w_trig_width;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = DELAY;
                            cnt_d   = delay_i;
                        end
                    end
                end
                DELAY: begin
                    if (tick_i) begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = PULSE;
                            cnt_d   = w_lat_width;
                            pulse_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                PULSE: begin
                    if (tick_i) begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = DONE;
                            pulse_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Parked until arm
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pulse_d = 1'b0;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = (state_q == DELAY) || (state_q == PULSE);
    assign done_o  = (state_q == DONE);

`ifdef SINHRON_PULSE_MISS_CNT_EN
    logic [3:0] miss_q, miss_d;

    // Count triggers lost because the channel was not idle; saturates at 15
    always_comb begin
        miss_d = miss_q;
        if (arm_i) begin
            miss_d = 4'd0;
        end else if (trig_i && (state_q != IDLE) && (miss_q != 4'hF)) begin
            miss_d = miss_q + 4'd1;
        end
    end

    // Miss counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_q <= 4'd0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_cnt_o = miss_q;
`endif

endmodule
`default_nettype wire

// File: rtl/sinhron_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sinhron_pulse_gen
//  Description : Converts rising edges of the timer-compare match flags into
//                delayed, fixed-width synchronisation strobes counted in
//                1 us ticks. Holds the tick generator, match-edge registers
//                and per-channel delay/width configuration; one
//                sinhron_pulse_ch per channel.
//                Optional macro SINHRON_PULSE_MISS_CNT_EN adds the miss_cnt
//                output (4 bits per channel).
//  Revision    : 1.0 - initial release
// ============================================================================
module sinhron_pulse_gen
    import sinhron_pkg::*;
#(
    parameter int N_CH     = 7,
    parameter int TICK_DIV = 20,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
`ifdef SINHRON_PULSE_MISS_CNT_EN
    output logic [4*N_CH-1:0]   miss_cnt,
`endif
    sinhron_pulse_gen_if.slave  bus
);

    logic [7:0]       tick_cnt_q;
    logic             w_tick;
    logic [N_CH-1:0]  mk_q;
    logic [N_CH-1:0]  w_trig;
    logic [N_CH-1:0]  w_pulse;
    logic [N_CH-1:0]  w_busy;
    logic [N_CH-1:0]  w_done;
    logic [CNT_W-1:0] delay_q [N_CH];
    logic [CNT_W-1:0] width_q [N_CH];

    // Tick fires on the last count of each period
    assign w_tick = (tick_cnt_q == 8'(TICK_DIV - 1));

    // Free-running tick divider, wraps after TICK_DIV clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= 8'd0;
        end else if (w_tick) begin
            tick_cnt_q <= 8'd0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
        end
    end

    // Previous match levels for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mk_q <= '0;
        end else begin
            mk_q <= bus.mk_in;
        end
    end

    assign w_trig = bus.mk_in & ~mk_q;

    // Configuration store; addresses outside the channel range match nothing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                delay_q[i] <= CNT_W'(DEF_DELAY);
                width_q[i] <= CNT_W'(DEF_WIDTH);
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.cfg_adr == 4'(i)) begin
                    delay_q[i] <= CNT_W'(bus.cfg_data[15:8]);
                    width_q[i] <= CNT_W'(bus.cfg_data[7:0]);
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        sinhron_pulse_ch #(
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick_i     (w_tick),
            .trig_i     (w_trig[gi]),
            .arm_i      (bus.arm[gi]),
            .delay_i    (delay_q[gi]),
            .width_i    (width_q[gi]),
            .pulse_o    (w_pulse[gi]),
            .busy_o     (w_busy[gi]),
            .done_o     (w_done[gi])
`ifdef SINHRON_PULSE_MISS_CNT_EN
            ,
            .miss_cnt_o (miss_cnt[gi*4 +: 4])
`endif
        );
    end

    assign bus.pulse_out = w_pulse;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.tick_out  = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_sinhron_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sinhron_pulse_gen
//  Description : Directed self-checking bench for sinhron_pulse_gen
//                (TICK_DIV = 20). Covers SINHRON_PULSE_MISS_CNT_EN when the
//                macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sinhron_pulse_gen;
    localparam int N_CH = 7;
    localparam int TD   = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sinhron_pulse_gen_if #(.N_CH(N_CH)) bus ();
`ifdef SINHRON_PULSE_MISS_CNT_EN
    logic [4*N_CH-1:0] miss_cnt;
`endif

    sinhron_pulse_gen #(
        .N_CH     (N_CH),
        .TICK_DIV (TD),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef SINHRON_PULSE_MISS_CNT_EN
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_ch(input logic [N_CH-1:0] m);
        bus.arm = m;
        step();
        bus.arm = '0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        bus.cfg_adr  = a;
        bus.cfg_data = d;
        bus.cfg_we   = 1'b1;
        step();
        bus.cfg_we   = 1'b0;
    endtask

    // Follows one channel from its trigger until DONE, counting delay and pulse cycles
    task automatic measure(input int ch, output logic p1, output logic b1,
                           output int dly, output int wid, output logic to);
        dly = 0; wid = 0; to = 1'b1; p1 = 1'b0; b1 = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (k == 0) begin
                p1 = bus.pulse_out[ch];
                b1 = bus.busy[ch];
            end
            if (bus.pulse_out[ch]) wid++;
            else if (bus.busy[ch]) dly++;
            if (bus.done[ch]) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== '0) $display("FAIL reset_outs: got %h want 0", {bus.pulse_out, bus.busy, bus.done});
        else n_pass++;
        n_checks++;
        if (bus.tick_out !== 1'b0) $display("FAIL reset_tick: got %b want 0", bus.tick_out);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== '0) $display("FAIL post_release_outs: got %h want 0", {bus.pulse_out, bus.busy, bus.done});
        else n_pass++;
    endtask

    task automatic test_tick();
        int t;
        t = 0;
        while (bus.tick_out !== 1'b1 && t < 100) begin step(); t++; end
        t = 0;
        step(); t++;
        n_checks++;
        if (bus.tick_out !== 1'b0) $display("FAIL tick_width: got %b want 0", bus.tick_out);
        else n_pass++;
        while (bus.tick_out !== 1'b1 && t < 100) begin step(); t++; end
        n_checks++;
        if (t != TD) $display("FAIL tick_period: got %0d want %0d", t, TD);
        else n_pass++;
    endtask

    task automatic test_default_pulse();
        logic p1, b1, to;
        int dly, wid;
        bus.mk_in[0] = 1'b1;
        measure(0, p1, b1, dly, wid, to);
        n_checks++;
        if (p1 !== 1'b1) $display("FAIL ch0_latency: got %b want 1", p1);
        else n_pass++;
        n_checks++;
        if (!(wid >= 181 && wid <= 200)) $display("FAIL ch0_width: got %0d want 181..200", wid);
        else n_pass++;
        n_checks++;
        if (to !== 1'b0) $display("FAIL ch0_done: got timeout=%b want 0", to);
        else n_pass++;
    endtask

    task automatic test_delay_cfg();
        logic p1, b1, to;
        int dly, wid;
        cfg_write(4'd2, 16'h0305);
        bus.mk_in[2] = 1'b1;
        measure(2, p1, b1, dly, wid, to);
        n_checks++;
        if ({b1, p1} !== 2'b10) $display("FAIL ch2_first_cycle: got busy,pulse=%b want 10", {b1, p1});
        else n_pass++;
        n_checks++;
        if (!(dly >= 41 && dly <= 60)) $display("FAIL ch2_delay: got %0d want 41..60", dly);
        else n_pass++;
        n_checks++;
        if (wid != 100) $display("FAIL ch2_width: got %0d want 100", wid);
        else n_pass++;
        n_checks++;
        if (to !== 1'b0) $display("FAIL ch2_done: got timeout=%b want 0", to);
        else n_pass++;
    endtask

    task automatic test_zero_width_rearm();
        logic p1, b1, to;
        int dly, wid;
        cfg_write(4'd1, 16'h0000);
        bus.mk_in[1] = 1'b1;
        measure(1, p1, b1, dly, wid, to);
        n_checks++;
        if (!(wid >= 1 && wid <= 20) || to) $display("FAIL ch1_w0_width: got %0d timeout=%b want 1..20", wid, to);
        else n_pass++;
        bus.mk_in[1] = 1'b0;
        step();
        bus.mk_in[1] = 1'b1;
        repeat (5) step();
        n_checks++;
        if ({bus.pulse_out[1], bus.busy[1], bus.done[1]} !== 3'b001) $display("FAIL ch1_done_ignores_edge: got %b want 001", {bus.pulse_out[1], bus.busy[1], bus.done[1]});
        else n_pass++;
        arm_ch(7'h02);
        n_checks++;
        if ({bus.pulse_out[1], bus.busy[1], bus.done[1]} !== 3'b000) $display("FAIL ch1_arm_idle: got %b want 000", {bus.pulse_out[1], bus.busy[1], bus.done[1]});
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (bus.busy[1] !== 1'b0) $display("FAIL ch1_held_level_no_retrig: got %b want 0", bus.busy[1]);
        else n_pass++;
        bus.mk_in[1] = 1'b0;
        step();
        bus.mk_in[1] = 1'b1;
        measure(1, p1, b1, dly, wid, to);
        n_checks++;
        if (p1 !== 1'b1) $display("FAIL ch1_repeat_latency: got %b want 1", p1);
        else n_pass++;
        n_checks++;
        if (!(wid >= 1 && wid <= 20) || to) $display("FAIL ch1_repeat_width: got %0d timeout=%b want 1..20", wid, to);
        else n_pass++;
    endtask

    task automatic test_cfg_midpulse_abort();
        int   wid;
        logic to;
        wid = 0; to = 1'b1;
        bus.mk_in[4] = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (k == 50) begin
                bus.cfg_adr  = 4'd4;
                bus.cfg_data = 16'h0032;
                bus.cfg_we   = 1'b1;
            end else if (k == 51) begin
                bus.cfg_we = 1'b0;
            end
            if (bus.pulse_out[4]) wid++;
            if (bus.done[4]) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++;
        if (!(wid >= 181 && wid <= 200) || to) $display("FAIL ch4_keeps_old_width: got %0d timeout=%b want 181..200", wid, to);
        else n_pass++;
        arm_ch(7'h10);
        bus.mk_in[4] = 1'b0;
        step();
        bus.mk_in[4] = 1'b1;
        repeat (300) step();
        n_checks++;
        if ({bus.pulse_out[4], bus.busy[4]} !== 2'b11) $display("FAIL ch4_new_width_active: got %b want 11", {bus.pulse_out[4], bus.busy[4]});
        else n_pass++;
        arm_ch(7'h10);
        n_checks++;
        if ({bus.pulse_out[4], bus.busy[4], bus.done[4]} !== 3'b000) $display("FAIL ch4_abort: got %b want 000", {bus.pulse_out[4], bus.busy[4], bus.done[4]});
        else n_pass++;
    endtask

    task automatic test_all_channels();
        int rise [N_CH];
        int fall [N_CH];
        for (int i = 0; i < N_CH; i++) begin
            cfg_write(4'(i), {8'(i + 1), 8'd2});
            rise[i] = -1;
            fall[i] = -1;
        end
        cfg_write(4'd8, 16'h0000);
        arm_ch(7'h7F);
        bus.mk_in = '0;
        step();
        bus.mk_in = 7'h7F;
        for (int k = 0; k < 2000; k++) begin
            step();
            for (int i = 0; i < N_CH; i++) begin
                if (bus.pulse_out[i] && rise[i] < 0) rise[i] = k;
                if (!bus.pulse_out[i] && rise[i] >= 0 && fall[i] < 0) fall[i] = k;
            end
            if (bus.done == 7'h7F) break;
        end
        n_checks++;
        if (bus.done !== 7'h7F) $display("FAIL all_done: got %h want 7f", bus.done);
        else n_pass++;
        for (int i = 0; i < N_CH; i++) begin
            n_checks++;
            if (fall[i] - rise[i] != 40) $display("FAIL all_width ch%0d: got %0d want 40", i, fall[i] - rise[i]);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (rise[i] - rise[0] != TD * i) $display("FAIL all_offset ch%0d: got %0d want %0d", i, rise[i] - rise[0], TD * i);
                else n_pass++;
            end
        end
    endtask

`ifdef SINHRON_PULSE_MISS_CNT_EN
    task automatic test_miss_cnt();
        arm_ch(7'h20);
        bus.mk_in = '0;
        step();
        bus.mk_in[5] = 1'b1;
        step();
        for (int e = 1; e <= 20; e++) begin
            bus.mk_in[5] = 1'b0;
            step();
            bus.mk_in[5] = 1'b1;
            step();
            if (e == 5) begin
                n_checks++;
                if (miss_cnt[23:20] !== 4'd5) $display("FAIL miss_cnt_5: got %0d want 5", miss_cnt[23:20]);
                else n_pass++;
            end
        end
        n_checks++;
        if (miss_cnt[23:20] !== 4'd15) $display("FAIL miss_cnt_sat: got %0d want 15", miss_cnt[23:20]);
        else n_pass++;
        bus.mk_in[5] = 1'b0;
        arm_ch(7'h20);
        n_checks++;
        if (miss_cnt[23:20] !== 4'd0) $display("FAIL miss_cnt_arm_clear: got %0d want 0", miss_cnt[23:20]);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_midrun();
        arm_ch(7'h7F);
        bus.mk_in = '0;
        step();
        bus.mk_in = 7'h7F;
        repeat (150) step();
        n_checks++;
        if (bus.pulse_out[6] !== 1'b1) $display("FAIL midrun_active: got %b want 1", bus.pulse_out[6]);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.pulse_out !== '0) $display("FAIL async_reset_pulse: got %h want 0", bus.pulse_out);
        else n_pass++;
        n_checks++;
        if ({bus.busy, bus.done} !== '0) $display("FAIL async_reset_status: got %h want 0", {bus.busy, bus.done});
        else n_pass++;
        n_checks++;
        if (bus.tick_out !== 1'b0) $display("FAIL async_reset_tick: got %b want 0", bus.tick_out);
        else n_pass++;
        repeat (3) step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.mk_in    = '0;
        bus.arm      = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_adr  = '0;
        bus.cfg_data = '0;
        test_reset();
        test_tick();
        test_default_pulse();
        test_delay_cfg();
        test_zero_width_rearm();
        test_cfg_midpulse_abort();
        test_all_channels();
`ifdef SINHRON_PULSE_MISS_CNT_EN
        test_miss_cnt();
`endif
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
